// File: rtl/vppm_pkg.sv
// Shared VPPM types and defaults for the Tx and Rx paths.
// Optional preamble build: define VPPM_PREAMBLE_EN.
package vppm_pkg;

  localparam int VPPM_SYM_LEN = 50;
  localparam int VPPM_PRE_LEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    SEND = 2'd2
  } vppm_state_t;

  // Width needed to hold values 0..n inclusive.
  function automatic int vppm_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vppm_sym_timer.sv
// VPPM symbol counter: wraps 0..SYM_LEN-1, held at 0 while disabled.
// Raises boundary on the last clock of each symbol.
module vppm_sym_timer
  import vppm_pkg::*;
#(
  parameter int SYM_LEN = VPPM_SYM_LEN,
  parameter int CW      = vppm_cnt_w(SYM_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          boundary
);

  localparam logic [CW-1:0] LAST = CW'(SYM_LEN - 1);

  assign boundary = enable & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vppm_tx_core.sv
// Parametrised VPPM transmitter with programmable dimming pulse width.
// Optional preamble insertion: define VPPM_PREAMBLE_EN.
module vppm_tx_core
  import vppm_pkg::*;
#(
  parameter int SYM_LEN  = VPPM_SYM_LEN,
  parameter int PRE_LEN  = VPPM_PRE_LEN,
  localparam int CW      = vppm_cnt_w(SYM_LEN)
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [CW-1:0] pulse_w,
  input  logic          bit_data,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic          tx_out,
  output logic          busy,
  output logic          cfg_err
);

  localparam logic [CW-1:0] SYM = CW'(SYM_LEN);

  if (SYM_LEN < 4 || PRE_LEN < 1) begin : g_bad_cfg
    $error("vppm_tx_core: SYM_LEN >= 4 and PRE_LEN >= 1 required");
  end

  logic [CW-1:0] cnt;
  logic          boundary;

  vppm_sym_timer #(
    .SYM_LEN (SYM_LEN),
    .CW      (CW)
  ) u_timer (
    .clk      (pclk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cnt      (cnt),
    .boundary (boundary)
  );

  vppm_state_t   state;
  vppm_state_t   state_nxt;
  logic          cur_bit;
  logic          cur_bit_nxt;
  logic [CW-1:0] pw_q;
  logic [CW-1:0] pw_clamp;
  logic          pw_bad;
  logic          hs;
  logic          data_sym;
  logic          sym_bit;
  logic [CW-1:0] lo;
  logic [CW:0]   hi;
  logic          wave;

  assign pw_bad = (pulse_w == '0) || (pulse_w >= SYM);

  always_comb begin
    pw_clamp = pulse_w;
    if (pulse_w == '0) begin
      pw_clamp = CW'(1);
    end else if (pulse_w >= SYM) begin
      pw_clamp = CW'(SYM_LEN - 1);
    end
  end

`ifdef VPPM_PREAMBLE_EN
  localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;

  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_cnt_nxt;
  logic          pre_last;

  assign pre_last  = (pre_cnt == PW'(PRE_LEN - 1));
  // The pending bit is only taken once the preamble has run out.
  assign bit_ready = boundary &
                     ((state == SEND) | ((state == PRE) & pre_last));
  assign data_sym  = (state != IDLE);
  assign sym_bit   = (state == PRE) ? ~pre_cnt[0] : cur_bit;
`else
  assign bit_ready = boundary;
  assign data_sym  = (state == SEND);
  assign sym_bit   = cur_bit;
`endif

  assign hs = bit_valid & bit_ready;

  always_comb begin
    state_nxt   = state;
    cur_bit_nxt = cur_bit;
`ifdef VPPM_PREAMBLE_EN
    pre_cnt_nxt = pre_cnt;
`endif
    if (boundary) begin
      if (hs) begin
        state_nxt   = SEND;
        cur_bit_nxt = bit_data;
      end else begin
        state_nxt   = IDLE;
      end
`ifdef VPPM_PREAMBLE_EN
      if (state == IDLE && bit_valid) begin
        state_nxt   = PRE;
        pre_cnt_nxt = '0;
      end else if (state == PRE && !pre_last) begin
        state_nxt   = PRE;
        pre_cnt_nxt = pre_cnt + 1'b1;
      end
`endif
    end
  end

  // Pulse window [lo, lo+pw_q) inside the symbol.
  always_comb begin
    lo = '0;
    unique case (1'b1)
      !data_sym:           lo = (SYM - pw_q) >> 1;
      data_sym && sym_bit: lo = SYM - pw_q;
      default:             lo = '0;
    endcase
  end

  assign hi   = {1'b0, lo} + {1'b0, pw_q};
  assign wave = (cnt >= lo) && ({1'b0, cnt} < hi);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_bit <= 1'b0;
      pw_q    <= CW'(1);
      cfg_err <= 1'b0;
      busy    <= 1'b0;
      tx_out  <= 1'b0;
    end else if (!enable) begin
      state   <= IDLE;
      cur_bit <= 1'b0;
      pw_q    <= CW'(1);
      cfg_err <= 1'b0;
      busy    <= 1'b0;
      tx_out  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur_bit <= cur_bit_nxt;
      busy    <= (state_nxt != IDLE);
      tx_out  <= wave;
      if (boundary) begin
        pw_q    <= pw_clamp;
        cfg_err <= pw_bad;
      end
    end
  end

`ifdef VPPM_PREAMBLE_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!enable) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt_nxt;
    end
  end
`endif

endmodule
